// File: rtl/bus_merge_pipe_pkg.sv
// Shared opcodes, width helper and overlap-bit operator for the bus merge pipeline.
// Imported by the interface, the skid buffer and the top.
package bus_merge_pipe_pkg;

  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_XOR  = 2'b10;
  localparam logic [1:0] OP_PASS = 2'b11;

  typedef enum logic [1:0] {
    MERGE_AND  = OP_AND,
    MERGE_OR   = OP_OR,
    MERGE_XOR  = OP_XOR,
    MERGE_PASS = OP_PASS
  } merge_op_e;

  // Output word width: both buses side by side, minus the shared overlap field.
  function automatic int merged_w(input int w, input int ov);
    return 2 * w - ov;
  endfunction

  // One overlap bit: a comes from in_a's high field, b from in_b's low field.
  function automatic logic merge_bit(input logic a, input logic b, input logic [1:0] op);
    logic r;
    r = a;
    case (merge_op_e'(op))
      MERGE_AND:  r = a & b;
      MERGE_OR:   r = a | b;
      MERGE_XOR:  r = a ^ b;
      MERGE_PASS: r = a;
      default:    r = a;
    endcase
    return r;
  endfunction

endpackage : bus_merge_pipe_pkg

// File: rtl/bus_merge_pipe_if.sv
// Producer/consumer bundle for bus_merge_pipe: input word + operator, merged output, beat count.
// slave is the block's view, master is the surrounding datapath's view.
interface bus_merge_pipe_if #(
  parameter int W     = 4,
  parameter int OV    = 2,
  parameter int CNT_W = 8
);
  import bus_merge_pipe_pkg::*;

  localparam int OUT_W = merged_w(W, OV);

  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_a;
  logic [W-1:0]     in_b;
  logic [1:0]       op_sel;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic [CNT_W-1:0] beat_cnt;

  modport slave (
    input  in_valid, in_a, in_b, op_sel, out_ready,
    output in_ready, out_valid, out_data, beat_cnt
  );

  modport master (
    output in_valid, in_a, in_b, op_sel, out_ready,
    input  in_ready, out_valid, out_data, beat_cnt
  );

endinterface : bus_merge_pipe_if

// File: rtl/bus_merge_skid.sv
// Two-entry skid buffer (output register + skid register), 1-cycle latency, full throughput.
// in_rdy_o is a flop (skid empty), so out_rdy_i has no combinational path to it.
module bus_merge_skid #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_vld_i,
  output logic              in_rdy_o,
  input  logic [DATA_W-1:0] in_dat_i,
  output logic              out_vld_o,
  input  logic              out_rdy_i,
  output logic [DATA_W-1:0] out_dat_o
);

  logic              out_vld_q, out_vld_d;
  logic [DATA_W-1:0] out_dat_q, out_dat_d;
  logic              skid_vld_q, skid_vld_d;
  logic [DATA_W-1:0] skid_dat_q, skid_dat_d;

  always_comb begin
    out_vld_d  = out_vld_q;
    out_dat_d  = out_dat_q;
    skid_vld_d = skid_vld_q;
    skid_dat_d = skid_dat_q;
    // A full skid implies a valid output register, and input is refused.
    if (skid_vld_q) begin
      if (out_rdy_i) begin
        out_dat_d  = skid_dat_q;
        skid_vld_d = 1'b0;
      end
    end else if (out_vld_q && !out_rdy_i) begin
      if (in_vld_i) begin
        skid_vld_d = 1'b1;
        skid_dat_d = in_dat_i;
      end
    end else begin
      out_vld_d = in_vld_i;
      if (in_vld_i) begin
        out_dat_d = in_dat_i;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld_q  <= 1'b0;
      out_dat_q  <= '0;
      skid_vld_q <= 1'b0;
      skid_dat_q <= '0;
    end else begin
      out_vld_q  <= out_vld_d;
      out_dat_q  <= out_dat_d;
      skid_vld_q <= skid_vld_d;
      skid_dat_q <= skid_dat_d;
    end
  end

  assign in_rdy_o  = ~skid_vld_q;
  assign out_vld_o = out_vld_q;
  assign out_dat_o = out_dat_q;

endmodule : bus_merge_skid

// File: rtl/bus_merge_pipe.sv
// Merges in_b (high), an operator-combined overlap and in_a (low) into one word; 1-cycle latency.
// Backpressure absorbed by a 2-entry skid buffer; beat_cnt counts accepted input words and wraps.
module bus_merge_pipe
  import bus_merge_pipe_pkg::*;
#(
  parameter int W     = 4,
  parameter int OV    = 2,
  parameter int CNT_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  bus_merge_pipe_if.slave     io
);

  localparam int OUT_W = merged_w(W, OV);

  logic [OUT_W-1:0] merged;
  logic             in_rdy;
  logic             in_acc;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;

  // Loops rather than slices so OV == W (empty low field) elaborates cleanly.
  always_comb begin
    merged = '0;
    for (int i = 0; i < W - OV; i++) begin
      merged[i] = io.in_a[i];
    end
    for (int i = 0; i < OV; i++) begin
      merged[W - OV + i] = merge_bit(io.in_a[W - OV + i], io.in_b[i], io.op_sel);
    end
    for (int i = OV; i < W; i++) begin
      merged[W - OV + i] = io.in_b[i];
    end
  end

  bus_merge_skid #(
    .DATA_W (OUT_W)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_vld_i  (io.in_valid),
    .in_rdy_o  (in_rdy),
    .in_dat_i  (merged),
    .out_vld_o (io.out_valid),
    .out_rdy_i (io.out_ready),
    .out_dat_o (io.out_data)
  );

  assign in_acc      = io.in_valid && in_rdy;
  assign io.in_ready = in_rdy;

  always_comb begin
    beat_cnt_d = beat_cnt_q;
    if (in_acc) begin
      beat_cnt_d = beat_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt_q <= '0;
    end else begin
      beat_cnt_q <= beat_cnt_d;
    end
  end

  assign io.beat_cnt = beat_cnt_q;

endmodule : bus_merge_pipe

// File: doc/bus_merge_pipe.md
Name: bus_merge_pipe

Overview:
- Parametrised, pipelined successor to the fixed 4-bit two-bus combiner.
- Merges two W-bit input buses into one (2W-OV)-bit output word:
  - upper field from in_b
  - overlap field combined by a selectable bitwise operator
  - lower field from in_a
- Adds a valid/ready handshake, a 2-entry skid buffer for full throughput under backpressure, and a wrapping accepted-beat counter.
- Sits between a producer and consumer bus stage in the FPGA datapath.

Parameters:
- W, 4, width of each input bus (W >= 2)
- OV, 2, overlap field width (1 <= OV <= W)
- CNT_W, 8, width of beat counter

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  input word valid
- in_ready  output  1  block can accept a word this cycle
- in_a  input  W  low-side bus
- in_b  input  W  high-side bus
- op_sel  input  2  overlap operator; sampled with data
- out_valid  output  1  output word valid
- out_ready  input  1  consumer accepts the word
- out_data  output  2W-OV  merged word
- beat_cnt  output  CNT_W  count of accepted input words, wraps

Behaviour:
- Clocking and reset: one clock domain. rst_n is asynchronous active-low: asserting it immediately clears all state.
- Reset values:
  - in_ready = 1
  - out_valid = 0
  - out_data = 0
  - beat_cnt = 0
  - skid buffer empty
- Merge function (combinational, computed before the register):
  - out_data[2W-OV-1 : W] = in_b[W-1 : OV]
  - out_data[W-1 : W-OV] = in_a[W-1 : W-OV] OP in_b[OV-1 : 0], bit i of the overlap pairs in_a[W-OV+i] with in_b[i]
  - out_data[W-OV-1 : 0] = in_a[W-OV-1 : 0]
  - When OV = W, the low field is empty.
- op_sel encoding:
  - 00 AND
  - 01 OR
  - 10 XOR
  - 11 PASS: overlap = in_a field, in_b low bits ignored
- Handshake:
  - A transfer occurs when valid && ready on the same edge.
  - Input latency is 1 cycle: a word accepted at edge N is visible on out_data with out_valid=1 after edge N.
  - out_data and out_valid hold stable while out_valid=1 && out_ready=0.
- Skid buffer (2 entries: output register + skid register):
  - in_ready is registered and equals "skid empty".
  - If a word is accepted while the output register is held (out_valid && !out_ready), it goes into the skid register. in_ready drops on the next cycle.
  - When the output is consumed and skid is full, skid moves to the output register. in_ready rises the next cycle.
  - Simultaneous accept and consume with skid empty: the new word goes straight to the output register. Throughput is 1 word/cycle.
  - Order is strictly FIFO; no word is dropped or duplicated.
- beat_cnt increments by 1 on every input transfer and wraps from 2^CNT_W-1 to 0. It is independent of the output side.
- Reset mid-operation: all buffered words are discarded, out_valid falls immediately (asynchronous), and beat_cnt clears.
- No combinational path from out_ready to in_ready.

Decomposition:
- Shared package/include holds:
  - opcode constants OP_AND=2'b00, OP_OR=2'b01, OP_XOR=2'b10, OP_PASS=2'b11
  - a width helper for 2W-OV
- One sub-module is natural: bus_merge_skid, a generic DATA_W 2-entry skid buffer with valid/ready on both sides.
- The top holds the merge function and the beat counter, and instantiates bus_merge_skid.

Test Plan (W=4, OV=2, CNT_W=8):
1. Reset: hold rst_n=0, then release -> in_ready=1, out_valid=0, out_data=0x00, beat_cnt=0.
2. Operator merge: in_a=4'b1101, in_b=4'b1011, out_ready=1, one beat per op_sel:
   - AND -> out_data=6'h2D
   - OR -> 6'h2D
   - XOR -> 6'h21
   - PASS -> 6'h2D
   - Each appears 1 cycle after acceptance; beat_cnt=4 at the end.
3. Backpressure: out_ready=0, send words A=(0x1,0x0) then B=(0xF,0xF) with AND:
   - out_data holds 6'h01 and in_ready drops after B is accepted.
   - A third word is refused.
   - Raise out_ready -> 6'h01 then 6'h3F, in order.
   - in_ready returns to 1.
4. Streaming: in_valid=1 and out_ready=1 for 20 cycles with an incrementing in_a -> one output per cycle, in order, no gaps, beat_cnt=20.
5. Counter wrap: 256 accepted beats -> beat_cnt returns to 0x00; the 257th accepted beat -> 0x01.
6. Reset mid-operation: skid full, pulse rst_n=0 asynchronously -> out_valid=0 immediately, in_ready=1 after release, beat_cnt=0, no stale word is output afterwards.
